// File: rtl/fall_scheduler.sv
// Level-dependent fall tick scheduler for the stacking game.
// Issues a held fall_req enable with req/ack handshake and overrun flag.
module fall_scheduler #(
    parameter int unsigned BASE_PERIOD = 50000000,
    parameter int unsigned STEP        = 4000000,
    parameter int unsigned MIN_PERIOD  = 5000000,
    parameter int unsigned FAST_PERIOD = 2500000,
    parameter int unsigned LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               drop,
    input  logic [LEVEL_W-1:0] level,
    input  logic               fall_ack,
    output logic               fall_req,
    output logic               overrun,
    output logic [1:0]         state,
    output logic [31:0]        period
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [31:0] BASE = 32'(BASE_PERIOD);
    localparam logic [31:0] STP  = 32'(STEP);
    localparam logic [31:0] MINP = 32'(MIN_PERIOD);
    localparam logic [31:0] FAST = 32'(FAST_PERIOD);

    state_t      st, st_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] prod, lvl_p, p_now;
    logic        req_n, ovr_n, ack_take;

    assign prod  = 32'(level) * STP;
    assign state = st;

    // Saturate at the floor before the subtraction could wrap
    always_comb begin
        lvl_p = BASE - prod;
        if (prod >= BASE - MINP) lvl_p = MINP;
        p_now = lvl_p;
        if (drop && lvl_p > FAST) p_now = FAST;
    end

    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        req_n    = fall_req;
        ovr_n    = overrun;
        ack_take = fall_ack && fall_req;
        if (ack_take) req_n = 1'b0;
        unique case (st)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    st_n  = RUN;
                    cnt_n = p_now - 32'd1;
                end
            end
            RUN, PAUSE: begin
                if (pause) begin
                    st_n = PAUSE;
                end else begin
                    st_n = RUN;
                    if (cnt == '0) begin
                        cnt_n = p_now - 32'd1;
                        req_n = 1'b1;
                        if (fall_req && !ack_take) ovr_n = 1'b1;
                    end else if (drop && cnt > FAST - 32'd1) begin
                        cnt_n = FAST - 32'd1;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
            end
            default: st_n = IDLE;
        endcase
        if (stop) begin
            st_n  = IDLE;
            cnt_n = '0;
            req_n = 1'b0;
            ovr_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            cnt      <= '0;
            fall_req <= 1'b0;
            overrun  <= 1'b0;
            period   <= '0;
        end else begin
            st       <= st_n;
            cnt      <= cnt_n;
            fall_req <= req_n;
            overrun  <= ovr_n;
            period   <= p_now;
        end
    end

endmodule

// File: tb/tb_fall_scheduler.sv
// Scoreboard bench for fall_scheduler: expected fall_req rise cycles are
// queued by stimulus and popped by a negedge monitor.
module tb_fall_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        drop = 1'b0;
    logic [3:0]  level = 4'd0;
    logic        fall_ack;
    logic        fall_req;
    logic        overrun;
    logic [1:0]  state;
    logic [31:0] period;

    logic auto_ack = 1'b0;
    logic ack_auto = 1'b0;
    logic man_ack = 1'b0;
    logic req_q = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_q[$];

    assign fall_ack = ack_auto | man_ack;

    fall_scheduler #(
        .BASE_PERIOD(20),
        .STEP(4),
        .MIN_PERIOD(6),
        .FAST_PERIOD(3),
        .LEVEL_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .pause(pause),
        .drop(drop),
        .level(level),
        .fall_ack(fall_ack),
        .fall_req(fall_req),
        .overrun(overrun),
        .state(state),
        .period(period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: score every rising edge of fall_req; optional auto-ack
    always @(negedge clk) begin
        if (fall_req && !req_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rise", cyc, -1);
            end else begin
                chk("rise_cycle", cyc, exp_q.pop_front());
            end
        end
        req_q    = fall_req;
        ack_auto = auto_ack && fall_req;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("state_run", int'(state), 1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_state", int'(state), 0);
        chk("stop_req", int'(fall_req), 0);
        chk("stop_ovr", int'(overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(fall_req), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_period", int'(period), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("period_l0", int'(period), 20);

        // Level 0, acked every tick
        auto_ack = 1'b1;
        do_start(t);
        exp_q.push_back(t + 20);
        exp_q.push_back(t + 40);
        exp_q.push_back(t + 60);
        wait_until(t + 62);
        chk("l0_period", int'(period), 20);
        chk("l0_ovr", int'(overrun), 0);
        do_stop();

        // Level 3, then 4 mid-count, then 15
        level = 4'd3;
        @(negedge clk);
        do_start(t);
        exp_q.push_back(t + 8);
        exp_q.push_back(t + 16);
        exp_q.push_back(t + 22);
        exp_q.push_back(t + 28);
        exp_q.push_back(t + 34);
        wait_until(t + 9);
        chk("l3_period", int'(period), 8);
        wait_until(t + 10);
        level = 4'd4;
        wait_until(t + 12);
        chk("l4_period", int'(period), 6);
        wait_until(t + 23);
        level = 4'd15;
        wait_until(t + 25);
        chk("l15_period", int'(period), 6);
        wait_until(t + 35);
        do_stop();

        // Drop clamp at cnt=15, then release
        level = 4'd0;
        @(negedge clk);
        do_start(t);
        exp_q.push_back(t + 8);
        exp_q.push_back(t + 11);
        exp_q.push_back(t + 14);
        exp_q.push_back(t + 17);
        exp_q.push_back(t + 37);
        wait_until(t + 4);
        drop = 1'b1;
        wait_until(t + 6);
        chk("drop_period", int'(period), 3);
        wait_until(t + 14);
        drop = 1'b0;
        wait_until(t + 20);
        chk("undrop_period", int'(period), 20);
        wait_until(t + 38);
        do_stop();

        // Never ack: overrun; ack coincident with expiry
        auto_ack = 1'b0;
        @(negedge clk);
        do_start(t);
        exp_q.push_back(t + 20);
        wait_until(t + 39);
        chk("ovr_before", int'(overrun), 0);
        wait_until(t + 40);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_req", int'(fall_req), 1);
        wait_until(t + 59);
        man_ack = 1'b1;
        wait_until(t + 60);
        man_ack = 1'b0;
        chk("ack_expiry_req", int'(fall_req), 1);
        wait_until(t + 61);
        chk("ack_expiry_hold", int'(fall_req), 1);
        man_ack = 1'b1;
        wait_until(t + 62);
        man_ack = 1'b0;
        chk("ack_clear", int'(fall_req), 0);
        chk("ovr_sticky", int'(overrun), 1);
        do_stop();

        // Pause 7 cycles right after a tick; ack while paused
        do_start(t);
        exp_q.push_back(t + 20);
        exp_q.push_back(t + 47);
        wait_until(t + 20);
        pause = 1'b1;
        for (int k = 21; k <= 27; k++) begin
            wait_until(t + k);
            if (k == 22) man_ack = 1'b1;
            if (k == 23) begin
                man_ack = 1'b0;
                chk("pause_ack", int'(fall_req), 0);
            end
            chk("pause_state", int'(state), 2);
        end
        pause = 1'b0;
        wait_until(t + 28);
        chk("resume_state", int'(state), 1);
        wait_until(t + 48);
        chk("pause_req", int'(fall_req), 1);
        do_stop();

        // start and stop together: stop wins
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_state", int'(state), 0);
        repeat (25) @(negedge clk);
        chk("ss_idle", int'(state), 0);

        // Async reset mid-RUN with overrun set
        do_start(t);
        exp_q.push_back(t + 20);
        wait_until(t + 41);
        chk("pre_rst_ovr", int'(overrun), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", int'(fall_req), 0);
        chk("arst_ovr", int'(overrun), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_period", int'(period), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fall_scheduler.md
# fall_scheduler

Sequences the falling-block timebase for the stacking game: replaces the free-running fall clock with a single-clock, level-dependent tick scheduler. Issues a held fall request to game logic at a programmable period that shortens with level and collapses to a fast period while drop is held. Supports start, stop, pause and a req/ack handshake with overrun detection. Sits between the 50 MHz system clock and the game FSM; game logic consumes `fall_req` as an enable and is never clocked by a derived clock.

## Interface
- `BASE_PERIOD`, default 50000000: tick period in clk cycles at level 0.
- `STEP`, default 4000000: period reduction per level.
- `MIN_PERIOD`, default 5000000: floor on level-derived period (≥2).
- `FAST_PERIOD`, default 2500000: period while `drop`=1 (≥2).
- `LEVEL_W`, default 4: width of `level`.

- `clk` in 1: 50 MHz system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse, begin scheduling.
- `stop` in 1: one-cycle pulse, return to idle.
- `pause` in 1: level; freezes countdown while high.
- `drop` in 1: level; selects fast period.
- `level` in LEVEL_W: current game level (unsigned).
- `fall_ack` in 1: game logic has consumed the tick.
- `fall_req` out 1: pending fall tick, held until acked.
- `overrun` out 1: sticky; a tick expired while `fall_req` was still high.
- `state` out 2: 0 IDLE, 1 RUN, 2 PAUSE.
- `period` out 32: period currently in effect (debug/display).

## Operation
- Period: L = BASE_PERIOD − level×STEP, computed in 32-bit unsigned; if level×STEP ≥ BASE_PERIOD − MIN_PERIOD then L = MIN_PERIOD (no wrap). P = min(L, FAST_PERIOD) if `drop`=1, else L. `period` is registered P, updated every cycle.
- 32-bit down-counter `cnt`. Loads P−1 on start and on every expiry (P sampled that cycle); `level` changes therefore take effect at the next reload.
- Drop clamp: in RUN, if `drop`=1 and `cnt` > FAST_PERIOD−1, `cnt` loads FAST_PERIOD−1 next cycle.
- FSM:
  - IDLE: `cnt` held 0, no requests. `start` → RUN (load P−1).
  - RUN: `cnt` decrements; at `cnt`=0 expiry → reload, raise request. `pause`=1 → PAUSE (no decrement that cycle). `start` in RUN ignored.
  - PAUSE: `cnt` frozen, `fall_req` and `overrun` held, ack still accepted. `pause`=0 → RUN.
  - `stop` from any state → IDLE, clears `fall_req`, `overrun`, `cnt`. `stop` and `start` same cycle: stop wins.
- Handshake: `fall_req` set on expiry, cleared the cycle after `fall_ack` sampled high with `fall_req`=1. Ack while `fall_req`=0 ignored. Expiry and ack same cycle: `fall_req` stays 1 (new tick). Expiry while `fall_req`=1 with no ack: `overrun` set sticky, `fall_req` stays 1; ticks never queue.
- `overrun` cleared only by `stop` or reset.

## Timing
- Reset (async, `rst_n`=0): `fall_req`=0, `overrun`=0, `state`=IDLE, `cnt`=0, `period`=0; `period` valid from first clk edge after release.
- `start` sampled at edge t: `state`=RUN after t; `fall_req` rises at edge t+P.
- With ack every tick, `fall_req` rising edges are exactly P cycles apart; pause cycles add 1:1 to that spacing.
- `fall_ack` at edge a: `fall_req`=0 after a.
- `stop` at edge s: all outputs at IDLE values after s.
- Reset mid-RUN: immediate return to reset values; no request survives.

## Test plan
(Bench parameters: BASE=20, STEP=4, MIN=6, FAST=3.)
- Level 0, start, ack each request one cycle after it rises → `fall_req` rises 20 cycles after start, then every 20 cycles; `period`=20, `overrun`=0.
- Level 3 then level 4 → `period`=8 then 6 (floor); level changed mid-count takes effect only after next expiry; level 15 → `period`=6, no wrap.
- Hold `drop` at cnt=15 → clamp to 2, request 3 cycles later, then every 3 cycles; release → next reload uses level period.
- Never ack → first request at 20 cycles, `overrun`=1 at 40, `fall_req` stays 1; ack in same cycle as expiry → `fall_req` stays high.
- Pause 7 cycles mid-count → request delayed by exactly 7; `state`=2 throughout; ack during pause clears `fall_req`.
- `start`+`stop` same cycle → stays IDLE; `stop` with `overrun`=1 → all cleared; `rst_n` low mid-RUN → outputs zero asynchronously.
